// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with in-flight PC tracking, response FIFO and redirect flush.
// Optional build macro FETCH_BYPASS_EN presents a response directly to decode when the FIFO is empty.
//
// state | meaning
// RUN   | issue fetches within the credit limit, queue in-order responses for decode
// FLUSH | drop responses that belong to requests issued before a redirect

module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic        IMEM_REQ_VALID,
  input  logic        IMEM_REQ_READY,
  output logic [31:0] IMEM_REQ_ADDR,
  input  logic        IMEM_RESP_VALID,
  input  logic [31:0] IMEM_RESP_DATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        FD_VALID,
  input  logic        FD_READY,
  output logic [31:0] FD_PC,
  output logic [31:0] FD_IR
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0]   DEPTH_CREDIT = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_FULL   = CW'(DEPTH);
  localparam logic [31:0]   RESET_PC_AL  = {RESET_PC[31:2], 2'b00};

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   fifo_pc [DEPTH];
  logic [31:0]   fifo_ir [DEPTH];
  logic [AW-1:0] fifo_rd;
  logic [AW-1:0] fifo_wr;
  logic [CW-1:0] count;
  logic [31:0]   infl_pc [DEPTH];
  logic [AW-1:0] infl_rd;
  logic [AW-1:0] infl_wr;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;

  logic          credit_ok;
  logic          req_valid;
  logic          req_fire;
  logic          resp_take;
  logic          fifo_empty;
  logic          bypass_sel;
  logic          fd_valid;
  logic          fd_fire;
  logic          push;
  logic          pop;
  logic [31:0]   fd_pc_sel;
  logic [31:0]   fd_ir_sel;
  logic [CW-1:0] redirect_discard;
  logic          flush_resp;
  logic          flush_last;
  logic          unused_redirect_lsb;

  assign unused_redirect_lsb = ^REDIRECT_PC[1:0];

  always_comb begin
    credit_ok  = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_CREDIT;
    req_valid  = RESET_N && (state == ST_RUN) && !REDIRECT && credit_ok;
    req_fire   = req_valid && IMEM_REQ_READY;
    // A response in RUN always retires the oldest in-flight request, even when a redirect drops it.
    resp_take  = RESET_N && (state == ST_RUN) && IMEM_RESP_VALID && (outstanding != '0);
    fifo_empty = (count == '0);
`ifdef FETCH_BYPASS_EN
    bypass_sel = fifo_empty && resp_take;
    fd_pc_sel  = bypass_sel ? infl_pc[infl_rd] : fifo_pc[fifo_rd];
    fd_ir_sel  = bypass_sel ? IMEM_RESP_DATA   : fifo_ir[fifo_rd];
`else
    bypass_sel = 1'b0;
    fd_pc_sel  = fifo_pc[fifo_rd];
    fd_ir_sel  = fifo_ir[fifo_rd];
`endif
    fd_valid   = RESET_N && !REDIRECT && (!fifo_empty || bypass_sel);
    fd_fire    = fd_valid && FD_READY;
    pop        = fd_fire && !fifo_empty;
    push       = resp_take && !REDIRECT && !(bypass_sel && fd_fire);
    redirect_discard = outstanding - CW'(resp_take);
    flush_resp = IMEM_RESP_VALID && (discard != '0);
    flush_last = flush_resp && (discard == CW'(1));
  end

  assign IMEM_REQ_VALID = req_valid;
  assign IMEM_REQ_ADDR  = RESET_N ? {fetch_pc[31:2], 2'b00} : RESET_PC_AL;
  assign FD_VALID       = fd_valid;
  assign FD_PC          = fd_valid ? fd_pc_sel : 32'h0;
  assign FD_IR          = fd_valid ? fd_ir_sel : 32'h0;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state       <= ST_RUN;
      fetch_pc    <= RESET_PC_AL;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      infl_rd     <= '0;
      infl_wr     <= '0;
    end else if (REDIRECT) begin
      fetch_pc    <= {REDIRECT_PC[31:2], 2'b00};
      count       <= '0;
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      outstanding <= '0;
      infl_rd     <= '0;
      infl_wr     <= '0;
      if (state == ST_RUN) begin
        discard <= redirect_discard;
        state   <= (redirect_discard != '0) ? ST_FLUSH : ST_RUN;
      end else if (flush_resp) begin
        // Nothing was issued during FLUSH, so a second redirect leaves the drop count alone.
        discard <= discard - CW'(1);
        if (flush_last) state <= ST_RUN;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
            infl_wr  <= infl_wr + AW'(1);
          end
          if (resp_take) infl_rd <= infl_rd + AW'(1);
          outstanding <= outstanding + CW'(req_fire) - CW'(resp_take);
          if (push) fifo_wr <= fifo_wr + AW'(1);
          if (pop)  fifo_rd <= fifo_rd + AW'(1);
          count <= count + CW'(push) - CW'(pop);
        end
        ST_FLUSH: begin
          if (flush_resp) begin
            discard <= discard - CW'(1);
            if (flush_last) state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (req_fire) infl_pc[infl_wr] <= fetch_pc;
    if (push) begin
      fifo_pc[fifo_wr] <= infl_pc[infl_rd];
      fifo_ir[fifo_wr] <= IMEM_RESP_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET_N) begin
      assert (!(push && !pop && (count == DEPTH_FULL)));
      assert (!((state == ST_RUN) && IMEM_RESP_VALID && (outstanding == '0)));
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized bench for fetch_queue with a memory model and an in-order PC/instruction scoreboard.
// Latency expectations follow FETCH_BYPASS_EN when that macro is defined for the build.

module tb_fetch_queue;

  localparam logic [31:0] RESET_PC_TB = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
  localparam int EXP_FIRST_FD = 1;
`else
  localparam int EXP_FIRST_FD = 2;
`endif

  logic        CLK;
  logic        RESET_N;
  logic        IMEM_REQ_VALID;
  logic        IMEM_REQ_READY;
  logic [31:0] IMEM_REQ_ADDR;
  logic        IMEM_RESP_VALID;
  logic [31:0] IMEM_RESP_DATA;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        FD_VALID;
  logic        FD_READY;
  logic [31:0] FD_PC;
  logic [31:0] FD_IR;

  fetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC_TB)) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .IMEM_REQ_VALID  (IMEM_REQ_VALID),
    .IMEM_REQ_READY  (IMEM_REQ_READY),
    .IMEM_REQ_ADDR   (IMEM_REQ_ADDR),
    .IMEM_RESP_VALID (IMEM_RESP_VALID),
    .IMEM_RESP_DATA  (IMEM_RESP_DATA),
    .REDIRECT        (REDIRECT),
    .REDIRECT_PC     (REDIRECT_PC),
    .FD_VALID        (FD_VALID),
    .FD_READY        (FD_READY),
    .FD_PC           (FD_PC),
    .FD_IR           (FD_IR)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;

  exp_t        exp_q[$];
  pend_t       pend[$];
  logic [31:0] model_pc;
  logic [31:0] prev_req_addr;
  int          cyc;
  int          n_checks;
  int          n_fail;
  int          tb_discard;
  int          last_due;
  int          req_count;
  int          fd_pops;
  int          wrap_seen;
  int          rdy_mode;
  int          lat_min;
  int          lat_max;
  int          mem_due;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: inputs change 1 time unit after the rising edge.
  task automatic step();
    pend_t p;
    @(posedge CLK);
    cyc++;
    #1;
    REDIRECT = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      IMEM_RESP_VALID = 1'b1;
      IMEM_RESP_DATA  = p.data;
    end else begin
      IMEM_RESP_VALID = 1'b0;
      IMEM_RESP_DATA  = $urandom;
    end
    case (rdy_mode)
      0:       IMEM_REQ_READY = 1'b1;
      1:       IMEM_REQ_READY = ($urandom_range(3) != 0);
      2:       IMEM_REQ_READY = (pend.size() == 0) && !IMEM_RESP_VALID;
      default: IMEM_REQ_READY = (pend.size() < 2);
    endcase
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    REDIRECT = 1'b0;
    IMEM_RESP_VALID = 1'b0;
    pend.delete();
    exp_q.delete();
    model_pc = RESET_PC_TB;
    prev_req_addr = 32'h1;
    tb_discard = 0;
    last_due = 0;
    req_count = 0;
    step();
    #2;
    check("rst_req_valid", 32'(IMEM_REQ_VALID), 32'h0);
    check("rst_fd_valid", 32'(FD_VALID), 32'h0);
    check("rst_fd_ir", FD_IR, 32'h0);
    check("rst_fd_pc", FD_PC, 32'h0);
    check("rst_req_addr", IMEM_REQ_ADDR, RESET_PC_TB);
    step();
    RESET_N = 1'b1;
  endtask

  // Request side of the scoreboard: predicts addresses and queues expected decode entries.
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET_N) begin
        if (tb_discard > 0) check("no_req_in_flush", 32'(IMEM_REQ_VALID), 32'h0);
        if (REDIRECT) begin
          check("req_off_on_redirect", 32'(IMEM_REQ_VALID), 32'h0);
          exp_q.delete();
          model_pc = {REDIRECT_PC[31:2], 2'b00};
          tb_discard = pend.size();
        end else begin
          if (IMEM_RESP_VALID && tb_discard > 0) tb_discard--;
          if (IMEM_REQ_VALID && IMEM_REQ_READY) begin
            check("req_addr", IMEM_REQ_ADDR, model_pc);
            mem_due = cyc + int'($urandom_range(lat_max, lat_min));
            if (mem_due <= last_due) mem_due = last_due + 1;
            last_due = mem_due;
            pend.push_back('{mem_due, mem_word(IMEM_REQ_ADDR)});
            exp_q.push_back('{model_pc, mem_word(model_pc)});
            if (prev_req_addr == 32'hFFFF_FFFC && IMEM_REQ_ADDR == 32'h0) wrap_seen++;
            prev_req_addr = IMEM_REQ_ADDR;
            model_pc = model_pc + 32'd4;
            req_count++;
          end
        end
      end
    end
  end

  // Monitor: pops the expected queue whenever decode takes an instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESET_N) begin
        if (!FD_VALID) check("fd_ir_idle_zero", FD_IR, 32'h0);
        if (REDIRECT) begin
          check("fd_off_on_redirect", 32'(FD_VALID), 32'h0);
        end else if (FD_VALID && FD_READY) begin
          fd_pops++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL fd_unexpected: got pc %h ir %h expected nothing (cycle %0d)", FD_PC, FD_IR, cyc);
          end else begin
            e = exp_q.pop_front();
            check("fd_pc", FD_PC, e.pc);
            check("fd_ir", FD_IR, e.ir);
          end
        end
      end
    end
  end

  initial begin
    int first;
    int found;
    cyc = 0; n_checks = 0; n_fail = 0; fd_pops = 0; wrap_seen = 0;
    RESET_N = 1'b0; IMEM_REQ_READY = 1'b0; IMEM_RESP_VALID = 1'b0; IMEM_RESP_DATA = 32'h0;
    REDIRECT = 1'b0; REDIRECT_PC = 32'h0; FD_READY = 1'b1;
    rdy_mode = 0; lat_min = 1; lat_max = 1;

    // Streaming with an always-ready 1-cycle memory
    do_reset();
    first = -1;
    for (int k = 0; k < 10; k++) begin
      #2;
      if (FD_VALID && first < 0) first = k;
      step();
    end
    check("first_fd_latency", 32'(first), 32'(EXP_FIRST_FD));
    for (int k = 0; k < 20; k++) step();

    // Decode stall: credit limit caps issued requests at the FIFO depth
    FD_READY = 1'b0;
    do_reset();
    for (int k = 0; k < 10; k++) step();
    #2;
    check("stall_req_count", 32'(req_count), 32'd4);
    check("stall_req_blocked", 32'(IMEM_REQ_VALID), 32'h0);
    fd_pops = 0;
    FD_READY = 1'b1;
    for (int k = 0; k < 20; k++) step();
    check("stall_drain_progress", 32'(fd_pops > 4), 32'h1);

    // Redirect with two slow responses in flight
    rdy_mode = 3; lat_min = 3; lat_max = 3;
    do_reset();
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step();
      if (pend.size() == 2) begin
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'h0000_0103;
        found = 1;
      end
    end
    check("flush_setup", 32'(found), 32'h1);
    step();
    #2;
    check("flush_blocks_req", 32'(IMEM_REQ_VALID), 32'h0);
    for (int k = 0; k < 15; k++) step();

    // Response coinciding with redirect while one request is outstanding
    rdy_mode = 2; lat_min = 2; lat_max = 2;
    do_reset();
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step();
      if (IMEM_RESP_VALID && pend.size() == 0) begin
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'h0000_0200;
        found = 1;
      end
    end
    check("same_cycle_setup", 32'(found), 32'h1);
    step();
    #2;
    check("no_flush_req_valid", 32'(IMEM_REQ_VALID), 32'h1);
    check("no_flush_req_addr", IMEM_REQ_ADDR, 32'h0000_0200);
    for (int k = 0; k < 12; k++) step();

    // Address wrap at the top of the address space
    rdy_mode = 1; lat_min = 1; lat_max = 3;
    step();
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'hFFFF_FFF2;
    for (int k = 0; k < 40; k++) step();
    check("wrap_reached", 32'(wrap_seen != 0), 32'h1);

    // Reset while flushing
    rdy_mode = 0; lat_min = 4; lat_max = 4; FD_READY = 1'b0;
    for (int k = 0; k < 3; k++) step();
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'h0000_0040;
    step();
    #2;
    check("pre_reset_flush_no_req", 32'(IMEM_REQ_VALID), 32'h0);
    FD_READY = 1'b1;
    do_reset();
    #2;
    check("post_reset_fd_valid", 32'(FD_VALID), 32'h0);
    check("post_reset_req_addr", IMEM_REQ_ADDR, RESET_PC_TB);
    check("post_reset_req_valid", 32'(IMEM_REQ_VALID), 32'h1);

    // Randomized traffic with stalls and redirects
    rdy_mode = 1; lat_min = 1; lat_max = 4;
    fd_pops = 0;
    for (int k = 0; k < 600; k++) begin
      step();
      FD_READY = ($urandom_range(3) != 0);
      if ($urandom_range(31) == 0) begin
        REDIRECT = 1'b1;
        REDIRECT_PC = $urandom;
      end
    end
    check("random_progress", 32'(fd_pops > 50), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
